// File: rtl/sobel_pkg.sv
// Types and default geometry shared by the Sobel result streamer and its FIFO.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } stream_state_t;

  localparam int DEF_OUTW = 238;
  localparam int DEF_OUTH = 238;
  localparam int OUTTOT   = DEF_OUTW * DEF_OUTH;
  localparam int PIX_W    = 8;

endpackage

// File: rtl/sobel_stream_fifo2.sv
// Two-entry registered FIFO holding pixel bytes returned by the output memory.
module sobel_stream_fifo2
  import sobel_pkg::*;
#(
  parameter int W = PIX_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic [1:0]   occ
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;
  logic         push_ok, pop_ok;

  // Guards keep the pointers coherent even if a caller misbehaves.
  assign pop_ok  = pop && (occ_q != 2'd0);
  assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (occ_q == 2'd0);
  assign occ   = occ_q;

endmodule

// File: rtl/sobel_result_streamer.sv
// Streams the finished Sobel output memory as a valid/ready byte stream with frame/line markers.
module sobel_result_streamer
  import sobel_pkg::*;
#(
  parameter int OUTW   = DEF_OUTW,
  parameter int OUTH   = DEF_OUTH,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              frame_done,
  output logic [31:0]       byte_count
);

  localparam int FRAME_TOT = OUTW * OUTH;
  localparam int COL_W     = (OUTW > 1) ? $clog2(OUTW) : 1;
  localparam int ROW_W     = (OUTH > 1) ? $clog2(OUTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_TOT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(OUTW - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(OUTH - 1);

  stream_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [31:0]       count_q, count_d;

  logic       fifo_empty;
  logic [1:0] fifo_occ;
  logic [7:0] fifo_head;
  logic       pop;
  logic       rd_issue;
  logic       last_col;
  logic       last_row;
  logic [2:0] level;

  assign pop      = !fifo_empty && m_ready;
  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);

  // Credit: bytes buffered plus in flight after this cycle's pop must leave room for one more.
  assign level    = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = (state_q == ST_STREAM) && (level < 3'd2);

  sobel_stream_fifo2 #(.W(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (mem_rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .occ       (fifo_occ)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    col_d      = col_q;
    row_d      = row_q;
    count_d    = count_q;
    inflight_d = rd_issue;

    if (pop) begin
      count_d = count_q + 32'd1;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
          count_d = '0;
        end
      end
      ST_STREAM: begin
        if (rd_issue) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      // All reads issued; finish once the final pixel leaves the FIFO.
      ST_DRAIN: begin
        if (pop && last_col && last_row) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      col_q      <= col_d;
      row_q      <= row_d;
      count_q    <= count_d;
    end
  end

  assign busy        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = addr_q;
  assign m_valid     = !fifo_empty;
  assign m_data      = m_valid ? fifo_head : 8'd0;
  assign m_sof       = m_valid && (row_q == '0) && (col_q == '0);
  assign m_eol       = m_valid && last_col;
  assign m_eof       = m_valid && last_col && last_row;
  assign frame_done  = (state_q == ST_DONE);
  assign byte_count  = count_q;

endmodule

// File: tb/tb_sobel_result_streamer.sv
// Directed bench: a 4x3 streamer checked every cycle against a byte-sequence model, plus a full 238x238 frame.
module tb_sobel_result_streamer;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int SN = SW * SH;
  localparam int LW = 238;
  localparam int LH = 238;
  localparam int LN = LW * LH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Small 4x3 instance
  logic       s_rst = 1'b1, s_start = 1'b0, s_ready = 1'b0;
  logic       s_busy, s_rd_en, s_valid, s_sof, s_eol, s_eof, s_done;
  logic [3:0] s_rd_addr;
  logic [7:0] s_rd_data, s_data;
  logic [31:0] s_cnt;

  sobel_result_streamer #(.OUTW(SW), .OUTH(SH), .ADDR_W(4)) dut_s (
    .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy),
    .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr), .mem_rd_data(s_rd_data),
    .m_valid(s_valid), .m_ready(s_ready), .m_data(s_data),
    .m_sof(s_sof), .m_eol(s_eol), .m_eof(s_eof),
    .frame_done(s_done), .byte_count(s_cnt)
  );

  always @(posedge clk) if (s_rd_en) s_rd_data <= 8'(s_rd_addr);

  // Default-size instance
  logic        l_rst = 1'b1, l_start = 1'b0, l_ready = 1'b1;
  logic        l_busy, l_rd_en, l_valid, l_sof, l_eol, l_eof, l_done;
  logic [15:0] l_rd_addr;
  logic [7:0]  l_rd_data, l_data;
  logic [31:0] l_cnt;

  sobel_result_streamer dut_l (
    .clk(clk), .rst(l_rst), .start(l_start), .busy(l_busy),
    .mem_rd_en(l_rd_en), .mem_rd_addr(l_rd_addr), .mem_rd_data(l_rd_data),
    .m_valid(l_valid), .m_ready(l_ready), .m_data(l_data),
    .m_sof(l_sof), .m_eol(l_eol), .m_eof(l_eof),
    .frame_done(l_done), .byte_count(l_cnt)
  );

  always @(posedge clk) if (l_rd_en) l_rd_data <= l_rd_addr[7:0];

  // Model of the small stream: phase 0 idle, 1 running, 2 frame_done cycle.
  int k = 0, rd_n = 0, phase = 0, start_cyc = 0;
  int first_valid_rel = -1, done_rel = -1;
  int eol_n = 0, sof_n = 0, eof_n = 0;
  bit armed = 0, prev_stall = 0;
  logic [7:0] prev_data;
  logic [2:0] prev_sb;

  always @(negedge clk) begin
    if (s_rst) begin
      armed = 1; phase = 0; k = 0; rd_n = 0; prev_stall = 0;
    end else if (armed) begin
      chk("busy", s_busy, phase == 1);
      chk("frame_done", s_done, phase == 2);
      chk("byte_count", s_cnt, k);
      if (phase != 1) chk("rd_en_outside_stream", s_rd_en, 0);
      if (s_rd_en) begin
        chk("rd_addr_order", s_rd_addr, rd_n);
        rd_n++;
      end
      if (prev_stall) begin
        chk("stall_valid_held", s_valid, 1);
        chk("stall_data_held", s_data, prev_data);
        chk("stall_sideband_held", {s_sof, s_eol, s_eof}, prev_sb);
      end
      if (s_valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
      if (s_valid && s_ready) begin
        chk("data", s_data, k[7:0]);
        chk("sof", s_sof, k == 0);
        chk("eol", s_eol, (k % SW) == SW - 1);
        chk("eof", s_eof, k == SN - 1);
        $display("byte %0d data=%0d sof=%0b eol=%0b eof=%0b rel_cycle=%0d",
                 k, s_data, s_sof, s_eol, s_eof, cyc - start_cyc);
        sof_n += int'(s_sof);
        eol_n += int'(s_eol);
        eof_n += int'(s_eof);
        k++;
      end
      chk("outstanding_le_2", (rd_n - k) <= 2, 1);
      prev_stall = s_valid && !s_ready;
      prev_data  = s_data;
      prev_sb    = {s_sof, s_eol, s_eof};
      case (phase)
        0: if (s_start) begin
             phase = 1; k = 0; rd_n = 0; start_cyc = cyc;
             first_valid_rel = -1; done_rel = -1;
             eol_n = 0; sof_n = 0; eof_n = 0;
           end
        1: if (k == SN) phase = 2;
        default: begin done_rel = cyc - start_cyc; phase = 0; end
      endcase
    end
  end

  task automatic start_small();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask

  // mode 0: ready high; 1: random ready; 2: ready high plus a start pulse during byte 5
  task automatic wait_small_done(input int mode, input int budget);
    bit pulsed = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_rel >= 0) break;
      s_ready = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_start = (mode == 2) && (k == 5) && !pulsed;
      if (s_start) pulsed = 1;
      tick();
    end
    s_start = 1'b0;
    chk("frame_completed_in_budget", done_rel >= 0, 1);
  endtask

  int lk = 0, l_bad = 0, l_eol_n = 0, l_eof_n = 0, l_sof_n = 0, l_done_rel = -1, l_start_cyc = 0;

  initial begin
    repeat (2) tick();
    s_rst = 1'b0;
    l_rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs_small",
        {s_busy, s_rd_en, s_rd_addr, s_valid, s_data, s_sof, s_eol, s_eof, s_done, s_cnt}, 0);
    chk("reset_outputs_large",
        {l_busy, l_rd_en, l_rd_addr, l_valid, l_data, l_sof, l_eol, l_eof, l_done, l_cnt}, 0);
    tick();

    // Full-rate frame
    s_ready = 1'b1;
    start_small();
    wait_small_done(0, 100);
    chk("t1_first_valid_cycle", first_valid_rel, 3);
    chk("t1_frame_done_cycle", done_rel, 15);
    chk("t1_byte_count", s_cnt, 12);
    chk("t1_eol_pulses", eol_n, 3);
    chk("t1_sof_pulses", sof_n, 1);
    chk("t1_eof_pulses", eof_n, 1);
    repeat (3) tick();

    // Random backpressure
    start_small();
    wait_small_done(1, 400);
    chk("t2_byte_count", s_cnt, 12);
    chk("t2_eol_pulses", eol_n, 3);
    chk("t2_eof_pulses", eof_n, 1);
    repeat (3) tick();

    // Sink stalled for 20 cycles from start
    s_ready = 1'b0;
    start_small();
    repeat (19) tick();
    chk("t3_reads_during_stall", rd_n, 2);
    chk("t3_no_bytes_during_stall", k, 0);
    chk("t3_rd_en_idle_in_stall", s_rd_en, 0);
    wait_small_done(0, 100);
    chk("t3_byte_count", s_cnt, 12);
    repeat (3) tick();

    // Start pulsed mid-frame
    s_ready = 1'b1;
    start_small();
    wait_small_done(2, 100);
    chk("t4_frame_done_cycle", done_rel, 15);
    chk("t4_byte_count", s_cnt, 12);
    repeat (3) tick();

    // Reset after byte 5 handshake
    start_small();
    for (int i = 0; i < 50 && k < 6; i++) tick();
    chk("t5_reached_byte5", k, 6);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    @(negedge clk);
    chk("t5_outputs_after_reset",
        {s_busy, s_rd_en, s_rd_addr, s_valid, s_data, s_sof, s_eol, s_eof, s_done, s_cnt}, 0);
    tick();
    start_small();
    wait_small_done(0, 100);
    chk("t5_frame_done_cycle", done_rel, 15);
    chk("t5_byte_count", s_cnt, 12);
    chk("t5_sof_pulses", sof_n, 1);

    // Default 238x238 frame at full rate
    l_ready = 1'b1;
    l_start = 1'b1;
    l_start_cyc = cyc;
    tick();
    l_start = 1'b0;
    for (int i = 0; i < 60000; i++) begin
      @(negedge clk);
      if (l_valid && l_ready) begin
        if (l_data != lk[7:0]) l_bad++;
        if (l_eol != ((lk % LW) == LW - 1)) l_bad++;
        if (l_eof != (lk == LN - 1)) l_bad++;
        if (l_sof != (lk == 0)) l_bad++;
        l_eol_n += int'(l_eol);
        l_eof_n += int'(l_eof);
        l_sof_n += int'(l_sof);
        lk++;
      end
      if (l_done) begin
        l_done_rel = cyc - l_start_cyc;
        break;
      end
    end
    chk("t6_bytes", lk, LN);
    chk("t6_byte_or_marker_errors", l_bad, 0);
    chk("t6_eol_pulses", l_eol_n, 238);
    chk("t6_eof_pulses", l_eof_n, 1);
    chk("t6_sof_pulses", l_sof_n, 1);
    chk("t6_frame_done_cycle", l_done_rel, 56647);
    chk("t6_byte_count", l_cnt, 56644);
    chk("t6_busy_low_at_done", l_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
